// File: rtl/Types.sv
// Shared scene and pixel types for the ray-tracing pipeline.
package Types;

  typedef logic [11:0] Color;

  typedef struct packed {
    logic signed [11:0] x;
    logic signed [11:0] y;
    logic signed [11:0] z;
    logic        [11:0] r;
  } Sphere;

endpackage

// File: rtl/raytracing_scheduler.sv
// Frame-level controller: walks rows and segments, launches the worker bank,
// then drains the worker colour buffers to the framebuffer in increasing x order.
`ifndef FP_B
`define FP_B 8
`endif
`ifndef PX_Y_SQRD_B
`define PX_Y_SQRD_B 20
`endif
`ifndef S_Y_SQRD_B
`define S_Y_SQRD_B 16
`endif

module raytracing_scheduler #(
  parameter int unsigned N_WORKERS        = 8,
  parameter int unsigned JOBS_SUBDIVISION = 10,
  parameter int unsigned WIDTH            = 640,
  parameter int unsigned HEIGHT           = 480
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  Types::Sphere                           sphere,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   activate,
  output logic [N_WORKERS*12-1:0]                pixel_start_x,
  output logic signed [21:0]                     doty,
  output logic [`PX_Y_SQRD_B-1:0]                pixel_y_sqrd,
  output logic [`S_Y_SQRD_B-1:0]                 sphere_y_sqrd,
  input  logic [N_WORKERS-1:0]                   worker_busy,
  input  logic [N_WORKERS*JOBS_SUBDIVISION*$bits(Types::Color)-1:0] worker_buffer,
  output logic                                   wr_valid,
  input  logic                                   wr_ready,
  output logic [18:0]                            wr_addr,
  output Types::Color                            wr_color
);

  localparam int unsigned SEG_W  = N_WORKERS * JOBS_SUBDIVISION;
  localparam int unsigned N_SEGS = WIDTH / SEG_W;
  localparam int unsigned CW     = $bits(Types::Color);
  localparam int unsigned RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned SW     = (N_SEGS > 1) ? $clog2(N_SEGS) : 1;
  localparam int unsigned KW     = (SEG_W > 1) ? $clog2(SEG_W) : 1;
  localparam int unsigned PYB    = `PX_Y_SQRD_B;
  localparam int unsigned SYB    = `S_Y_SQRD_B;

  typedef enum logic [2:0] {
    IDLE, ROW_SETUP, ACTIVATE, WAIT_BUSY, WAIT_DONE, DRAIN, RELEASE, DONE
  } state_t;

  state_t             state, state_next;
  logic [RW-1:0]      row;
  logic [SW-1:0]      seg;
  logic [KW-1:0]      k;
  logic [18:0]        base;
  Types::Sphere       sphere_q;
  logic signed [11:0] pixel_y;
  logic signed [23:0] dy_prod, py_prod, ys_prod;
  logic               seg_last, row_last, k_last;
  int unsigned        buf_idx;
  logic               unused_sphere;

  assign pixel_y  = 12'(row) - 12'(HEIGHT / 2);
  assign dy_prod  = pixel_y * sphere_q.y;
  assign py_prod  = pixel_y * pixel_y;
  assign ys_prod  = sphere_q.y * sphere_q.y;
  assign seg_last = (seg == SW'(N_SEGS - 1));
  assign row_last = (row == RW'(HEIGHT - 1));
  assign k_last   = (k == KW'(SEG_W - 1));
  assign unused_sphere = ^{sphere_q.x, sphere_q.z, sphere_q.r};

  function automatic logic [N_WORKERS*12-1:0] start_xs(input int unsigned s);
    logic [N_WORKERS*12-1:0] xs;
    int x;
    xs = '0;
    for (int unsigned w = 0; w < N_WORKERS; w++) begin
      x = int'(s * SEG_W + w) - int'(WIDTH / 2);
      xs[w*12 +: 12] = 12'(x);
    end
    return xs;
  endfunction

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    activate   = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_color   = '0;
    // Drain order interleaves workers: pixel k belongs to worker k%N, job k/N.
    buf_idx    = ((32'(k) % N_WORKERS) * JOBS_SUBDIVISION + 32'(k) / N_WORKERS) * CW;
    unique case (state)
      IDLE:      if (start) state_next = ROW_SETUP;
      ROW_SETUP: begin
        busy       = 1'b1;
        state_next = ACTIVATE;
      end
      ACTIVATE: begin
        busy       = 1'b1;
        activate   = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        busy     = 1'b1;
        activate = 1'b1;
        if (&worker_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy     = 1'b1;
        activate = 1'b1;
        if (worker_busy == '0) state_next = DRAIN;
      end
      DRAIN: begin
        busy     = 1'b1;
        activate = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = base + 19'(k);
        wr_color = worker_buffer[buf_idx +: CW];
        if (wr_ready && k_last) state_next = RELEASE;
      end
      RELEASE: begin
        busy = 1'b1;
        if (!seg_last)      state_next = ACTIVATE;
        else if (!row_last) state_next = ROW_SETUP;
        else                state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      row           <= '0;
      seg           <= '0;
      k             <= '0;
      base          <= '0;
      sphere_q      <= '0;
      pixel_start_x <= '0;
      doty          <= '0;
      pixel_y_sqrd  <= '0;
      sphere_y_sqrd <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: if (start) begin
          row      <= '0;
          seg      <= '0;
          k        <= '0;
          base     <= '0;
          sphere_q <= sphere;
        end
        ROW_SETUP: begin
          doty          <= 22'(dy_prod);
          pixel_y_sqrd  <= PYB'(py_prod);
          sphere_y_sqrd <= SYB'(ys_prod >>> `FP_B);
          pixel_start_x <= start_xs(32'(seg));
        end
        DRAIN: if (wr_ready) k <= k_last ? '0 : k + 1'b1;
        RELEASE: begin
          // Segments are contiguous in the framebuffer, so the base just advances.
          base <= base + 19'(SEG_W);
          k    <= '0;
          if (!seg_last) begin
            seg           <= seg + 1'b1;
            pixel_start_x <= start_xs(32'(seg) + 32'd1);
          end else begin
            seg <= '0;
            if (!row_last) row <= row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_raytracing_scheduler.sv
// Directed bench for raytracing_scheduler on a 2x2-worker, 8x2-pixel screen.
`ifndef FP_B
`define FP_B 8
`endif
`ifndef PX_Y_SQRD_B
`define PX_Y_SQRD_B 20
`endif
`ifndef S_Y_SQRD_B
`define S_Y_SQRD_B 16
`endif

module tb_raytracing_scheduler;

  localparam int unsigned NW = 2, JS = 2, W = 8, H = 2, CW = 12, BUSY_LEN = 5;

  logic clk = 1'b0;
  logic rst, start;
  Types::Sphere sphere;
  logic busy, frame_done, activate, wr_valid, wr_ready;
  logic [NW*12-1:0] pixel_start_x;
  logic signed [21:0] doty;
  logic [`PX_Y_SQRD_B-1:0] pixel_y_sqrd;
  logic [`S_Y_SQRD_B-1:0] sphere_y_sqrd;
  logic [NW-1:0] wbusy;
  logic [NW*JS*CW-1:0] wbuf;
  logic [18:0] wr_addr;
  Types::Color wr_color;

  int compared = 0, mismatched = 0;
  bit bp_en = 1'b0;
  logic tog = 1'b1;

  raytracing_scheduler #(.N_WORKERS(NW), .JOBS_SUBDIVISION(JS), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .sphere(sphere), .busy(busy),
    .frame_done(frame_done), .activate(activate), .pixel_start_x(pixel_start_x),
    .doty(doty), .pixel_y_sqrd(pixel_y_sqrd), .sphere_y_sqrd(sphere_y_sqrd),
    .worker_busy(wbusy), .worker_buffer(wbuf), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_color(wr_color));

  always #5 clk = ~clk;

  always @(posedge clk) tog <= bp_en ? ~tog : 1'b1;
  assign wr_ready = tog;

  // Worker model: busy for BUSY_LEN cycles per activation; colour tagged with activation index.
  int wcnt, act_idx;
  bit started;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wbusy <= '0; wcnt <= 0; started <= 1'b0; act_idx <= 0;
      wbuf <= {NW*JS{12'hABC}};
    end else begin
      if (!busy) act_idx <= 0;
      if (activate && !started) begin
        started <= 1'b1; wbusy <= '1; wcnt <= BUSY_LEN; act_idx <= act_idx + 1;
        for (int w = 0; w < NW; w++)
          for (int j = 0; j < JS; j++)
            wbuf[(w*JS+j)*CW +: CW] <= 12'(256*w + j + 16*act_idx);
      end else begin
        if (!activate) started <= 1'b0;
        if (wbusy != '0) begin
          if (wcnt <= 1) wbusy <= '0;
          wcnt <= wcnt - 1;
        end
      end
    end
  end

  logic [18:0] wa_q[$];
  logic [11:0] wc_q[$];
  logic [NW*12-1:0] psx_q[$];
  logic [21:0] dy_q[$];
  logic [`PX_Y_SQRD_B-1:0] pys_q[$];
  logic [`S_Y_SQRD_B-1:0] sys_q[$];
  int vcnt = 0, gapcnt = 0, done_cnt = 0, stall_bad = 0, hold_bad = 0;
  logic act_prev = 1'b0, stalled = 1'b0;
  logic [18:0] hold_a;
  logic [11:0] hold_c;
  logic [NW*12+22+`PX_Y_SQRD_B+`S_Y_SQRD_B-1:0] prev_cfg;

  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin wa_q.push_back(wr_addr); wc_q.push_back(wr_color); end
    if (wr_valid) vcnt <= vcnt + 1;
    if (busy && !activate) gapcnt <= gapcnt + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
    if (activate && !act_prev) begin
      psx_q.push_back(pixel_start_x); dy_q.push_back(doty);
      pys_q.push_back(pixel_y_sqrd); sys_q.push_back(sphere_y_sqrd);
    end
    if (activate && act_prev && {pixel_start_x, doty, pixel_y_sqrd, sphere_y_sqrd} !== prev_cfg)
      hold_bad <= hold_bad + 1;
    if (stalled && !rst && (!wr_valid || wr_addr !== hold_a || wr_color !== hold_c))
      stall_bad <= stall_bad + 1;
    prev_cfg <= {pixel_start_x, doty, pixel_y_sqrd, sphere_y_sqrd};
    stalled  <= wr_valid && !wr_ready && !rst;
    hold_a   <= wr_addr;
    hold_c   <= wr_color;
    act_prev <= activate;
  end

  function automatic logic [11:0] exp_color(input int a);
    int k;
    k = a % 4;
    return 12'(256*(k % 2) + k/2 + 16*(a/4));
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input logic signed [11:0] y, output bit ok);
    sphere = '{x: 12'sd5, y: y, z: -12'sd7, r: 12'd9};
    start = 1'b1; tick(); start = 1'b0;
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL busy_after_start got %b want 1", busy); end
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
    compared++;
    if (!ok) begin mismatched++; $display("FAIL frame_timeout got no frame_done want frame_done"); end
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sphere = '0;
    tick(); tick();
    compared += 10;
    if (busy !== 1'b0)          begin mismatched++; $display("FAIL rst_busy got %b want 0", busy); end
    if (frame_done !== 1'b0)    begin mismatched++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
    if (activate !== 1'b0)      begin mismatched++; $display("FAIL rst_activate got %b want 0", activate); end
    if (wr_valid !== 1'b0)      begin mismatched++; $display("FAIL rst_wr_valid got %b want 0", wr_valid); end
    if (wr_addr !== '0)         begin mismatched++; $display("FAIL rst_wr_addr got %h want 0", wr_addr); end
    if (wr_color !== '0)        begin mismatched++; $display("FAIL rst_wr_color got %h want 0", wr_color); end
    if (pixel_start_x !== '0)   begin mismatched++; $display("FAIL rst_psx got %h want 0", pixel_start_x); end
    if (doty !== '0)            begin mismatched++; $display("FAIL rst_doty got %h want 0", doty); end
    if (pixel_y_sqrd !== '0)    begin mismatched++; $display("FAIL rst_pysq got %h want 0", pixel_y_sqrd); end
    if (sphere_y_sqrd !== '0)   begin mismatched++; $display("FAIL rst_sysq got %h want 0", sphere_y_sqrd); end
    rst = 1'b0; tick(); tick();
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic check_frame_writes(input string tag, input int a0);
    compared++;
    if (wa_q.size() - a0 != 16) begin
      mismatched++; $display("FAIL %s_write_count got %0d want 16", tag, wa_q.size() - a0);
    end else begin
      for (int i = 0; i < 16; i++) begin
        compared += 2;
        if (wa_q[a0+i] !== 19'(i)) begin
          mismatched++; $display("FAIL %s_addr[%0d] got %0d want %0d", tag, i, wa_q[a0+i], i);
        end
        if (wc_q[a0+i] !== exp_color(i)) begin
          mismatched++; $display("FAIL %s_color[%0d] got %h want %h", tag, i, wc_q[a0+i], exp_color(i));
        end
      end
    end
  endtask

  task automatic test_full_frame();
    int a0, p0, d0, v0, g0, h0;
    bit ok;
    a0 = wa_q.size(); p0 = psx_q.size(); d0 = done_cnt; v0 = vcnt; g0 = gapcnt; h0 = hold_bad;
    run_frame(12'sd100, ok);
    check_frame_writes("full", a0);
    compared += 5;
    if (done_cnt - d0 != 1) begin mismatched++; $display("FAIL full_done_count got %0d want 1", done_cnt - d0); end
    if (vcnt - v0 != 16)    begin mismatched++; $display("FAIL full_valid_cycles got %0d want 16", vcnt - v0); end
    if (gapcnt - g0 != 6)   begin mismatched++; $display("FAIL full_inactive_cycles got %0d want 6", gapcnt - g0); end
    if (hold_bad != h0)     begin mismatched++; $display("FAIL full_cfg_hold got %0d changes want 0", hold_bad - h0); end
    if (psx_q.size() - p0 != 4) begin
      mismatched++; $display("FAIL full_activations got %0d want 4", psx_q.size() - p0);
    end else begin
      compared += 10;
      if (psx_q[p0]   !== 24'hFFDFFC) begin mismatched++; $display("FAIL psx_s0 got %h want FFDFFC", psx_q[p0]); end
      if (psx_q[p0+1] !== 24'h001000) begin mismatched++; $display("FAIL psx_s1 got %h want 001000", psx_q[p0+1]); end
      if (psx_q[p0+2] !== 24'hFFDFFC) begin mismatched++; $display("FAIL psx_r1s0 got %h want FFDFFC", psx_q[p0+2]); end
      if (psx_q[p0+3] !== 24'h001000) begin mismatched++; $display("FAIL psx_r1s1 got %h want 001000", psx_q[p0+3]); end
      if (dy_q[p0]    !== 22'h3FFF9C) begin mismatched++; $display("FAIL doty_r0 got %h want 3FFF9C", dy_q[p0]); end
      if (dy_q[p0+2]  !== 22'h000000) begin mismatched++; $display("FAIL doty_r1 got %h want 0", dy_q[p0+2]); end
      if (pys_q[p0]   !== 20'd1)      begin mismatched++; $display("FAIL pysq_r0 got %0d want 1", pys_q[p0]); end
      if (pys_q[p0+2] !== 20'd0)      begin mismatched++; $display("FAIL pysq_r1 got %0d want 0", pys_q[p0+2]); end
      if (sys_q[p0]   !== 16'd39)     begin mismatched++; $display("FAIL sysq_r0 got %0d want 39", sys_q[p0]); end
      if (sys_q[p0+2] !== 16'd39)     begin mismatched++; $display("FAIL sysq_r1 got %0d want 39", sys_q[p0+2]); end
    end
  endtask

  task automatic test_backpressure();
    int a0, s0, v0, d0;
    bit ok;
    a0 = wa_q.size(); s0 = stall_bad; v0 = vcnt; d0 = done_cnt;
    bp_en = 1'b1;
    run_frame(12'sd100, ok);
    bp_en = 1'b0;
    tick();
    check_frame_writes("bp", a0);
    compared += 3;
    if (stall_bad != s0)     begin mismatched++; $display("FAIL bp_hold got %0d violations want 0", stall_bad - s0); end
    if (vcnt - v0 <= 16)     begin mismatched++; $display("FAIL bp_stalls got %0d valid cycles want >16", vcnt - v0); end
    if (done_cnt - d0 != 1)  begin mismatched++; $display("FAIL bp_done_count got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_start_ignored();
    int a0, p0, d0;
    bit ok;
    a0 = wa_q.size(); p0 = psx_q.size(); d0 = done_cnt;
    sphere = '{x: 12'sd1, y: -12'sd300, z: 12'sd2, r: 12'd3};
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    sphere = '{x: 12'sd1, y: 12'sd50, z: 12'sd2, r: 12'd3};
    start = 1'b1; tick(); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    compared += 4;
    if (!ok)                begin mismatched++; $display("FAIL ign_timeout got no frame_done want frame_done"); end
    if (busy !== 1'b0)      begin mismatched++; $display("FAIL ign_start_at_done got busy=%b want 0", busy); end
    if (done_cnt - d0 != 1) begin mismatched++; $display("FAIL ign_done_count got %0d want 1", done_cnt - d0); end
    if (wa_q.size() - a0 != 16) begin mismatched++; $display("FAIL ign_write_count got %0d want 16", wa_q.size() - a0); end
    if (psx_q.size() - p0 == 4) begin
      compared += 3;
      if (dy_q[p0]    !== 22'h00012C) begin mismatched++; $display("FAIL ign_doty_r0 got %h want 00012C", dy_q[p0]); end
      if (sys_q[p0]   !== 16'd351)    begin mismatched++; $display("FAIL ign_sysq_r0 got %0d want 351", sys_q[p0]); end
      if (sys_q[p0+2] !== 16'd351)    begin mismatched++; $display("FAIL ign_sysq_r1 got %0d want 351", sys_q[p0+2]); end
    end else begin
      compared++; mismatched++;
      $display("FAIL ign_activations got %0d want 4", psx_q.size() - p0);
    end
  endtask

  task automatic test_reset_in_drain();
    int a0, d0;
    bit ok;
    sphere = '{x: 12'sd0, y: 12'sd100, z: 12'sd0, r: 12'd1};
    start = 1'b1; tick(); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_valid) begin ok = 1'b1; break; end
    end
    compared++;
    if (!ok) begin mismatched++; $display("FAIL rd_no_drain got wr_valid=0 want 1"); end
    @(posedge clk); #2; rst = 1'b1; #1;
    compared += 6;
    if (busy !== 1'b0)        begin mismatched++; $display("FAIL rd_busy got %b want 0", busy); end
    if (activate !== 1'b0)    begin mismatched++; $display("FAIL rd_activate got %b want 0", activate); end
    if (wr_valid !== 1'b0)    begin mismatched++; $display("FAIL rd_wr_valid got %b want 0", wr_valid); end
    if (wr_addr !== '0)       begin mismatched++; $display("FAIL rd_wr_addr got %h want 0", wr_addr); end
    if (wr_color !== '0)      begin mismatched++; $display("FAIL rd_wr_color got %h want 0", wr_color); end
    if ({pixel_start_x, doty, pixel_y_sqrd, sphere_y_sqrd} !== '0) begin
      mismatched++; $display("FAIL rd_row_terms got %h want 0", {pixel_start_x, doty, pixel_y_sqrd, sphere_y_sqrd});
    end
    @(posedge clk); #1; rst = 1'b0; tick();
    a0 = wa_q.size(); d0 = done_cnt;
    run_frame(12'sd100, ok);
    check_frame_writes("rd", a0);
    compared++;
    if (done_cnt - d0 != 1) begin mismatched++; $display("FAIL rd_done_count got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_start_ignored();
    test_reset_in_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/raytracing_scheduler.md
# raytracing_scheduler

Frame-level controller for the bank of ray-tracing workers. It walks the screen row by row and segment by segment. For each segment it:
- computes the per-row terms the workers share,
- drives each worker's start pixel and `activate`,
- waits for every worker to finish,
- drains the worker colour buffers to the framebuffer as a pixel write stream, in increasing x order.

It sits between the frame/sphere source and the framebuffer writer.

## Interface
- `N_WORKERS`, 8, number of worker instances driven in parallel.
- `JOBS_SUBDIVISION`, 10, pixels per worker per segment; segment width `SEG_W = N_WORKERS*JOBS_SUBDIVISION`.
- `WIDTH`, 640, screen width in pixels; must be a multiple of `SEG_W`.
- `HEIGHT`, 480, screen height in pixels.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a frame when idle.
- `sphere`  in  `Types::Sphere`  scene sphere; captured on an accepted `start`.
- `busy`  out  1  high from the accepted `start` until `frame_done`.
- `frame_done`  out  1  one-cycle pulse after the last pixel of the frame is accepted.
- `activate`  out  1  common activate to all workers.
- `pixel_start_x`  out  `N_WORKERS*12`  signed, per worker: `seg_x0 + w`.
- `doty`  out  22  signed, `pixel_y * sphere.y`.
- `pixel_y_sqrd`  out  `` `PX_Y_SQRD_B ``  `pixel_y**2`.
- `sphere_y_sqrd`  out  `` `S_Y_SQRD_B ``  `(sphere.y**2) >>> `FP_B`.
- `worker_busy`  in  `N_WORKERS`  per-worker busy.
- `worker_buffer`  in  `N_WORKERS*JOBS_SUBDIVISION*$bits(Types::Color)`  worker colour buffers; worker w, job j.
- `wr_valid`  out  1  pixel write valid.
- `wr_ready`  in  1  framebuffer accepts the write.
- `wr_addr`  out  19  `row*WIDTH + x_index`.
- `wr_color`  out  `Types::Color`  pixel colour.

## Operation
Coordinates and sphere:
- `pixel_y = row - HEIGHT/2`, for `row` 0..HEIGHT-1.
- `seg_x0 = -WIDTH/2 + seg*SEG_W`, for `seg` 0..WIDTH/SEG_W-1.
- The sphere is latched on an accepted `start`; later changes on `sphere` are ignored until the next frame.

States:
- IDLE:
  - An accepted `start` resets `row` and `seg` to 0, latches the sphere and goes to ROW_SETUP.
  - `start` is ignored in every other state.
- ROW_SETUP (1 cycle): registers `doty`, `pixel_y_sqrd` and `sphere_y_sqrd` for the current row; next state ACTIVATE.
- ACTIVATE: drives `pixel_start_x`, sets `activate`=1, goes to WAIT_BUSY.
- WAIT_BUSY: holds `activate`; when `&worker_busy`, goes to WAIT_DONE.
- WAIT_DONE: holds `activate`; when `worker_busy == 0`, goes to DRAIN with `k` = 0.
- DRAIN: emits the segment's pixels in order k = 0..SEG_W-1:
  - `k` maps to worker `w = k % N_WORKERS`, job `j = k / N_WORKERS`.
  - `wr_color = buffer[w][j]`, `wr_addr = row*WIDTH + seg*SEG_W + k`.
  - `k` advances only on `wr_valid && wr_ready`.
  - After the last accepted pixel, go to RELEASE.
- RELEASE (1 cycle): `activate`=0, which returns the workers to READY. Then:
  - more segments remain in the row: `seg++`, go to ACTIVATE;
  - row complete and rows remain: `seg`=0, `row++`, go to ROW_SETUP;
  - last row complete: go to DONE.
- DONE (1 cycle): `frame_done`=1, `busy`=0, go to IDLE.

Output invariants:
- `activate` stays low outside ACTIVATE, WAIT_BUSY, WAIT_DONE and DRAIN.
- `pixel_start_x`, `doty`, `pixel_y_sqrd` and `sphere_y_sqrd` stay constant while `activate` is high.

Arithmetic:
- `pixel_start_x` is 12-bit two's complement.
- `doty` is the full signed product, truncated to 22 bits.
- `wr_addr` never exceeds `WIDTH*HEIGHT-1`.

## Timing
Reset values:
- All outputs are 0: `busy`, `frame_done`, `activate`, `wr_valid`, `wr_addr`, `wr_color`, `pixel_start_x`, `doty`, `pixel_y_sqrd`, `sphere_y_sqrd`.
- State is IDLE.

Latencies:
- Accepted `start` → `busy`=1 next cycle.
- ROW_SETUP to first `activate`=1: 1 cycle.
- `worker_busy` falling to 0 → first `wr_valid` 1 cycle later.
- With `wr_ready` tied high, DRAIN takes exactly `SEG_W` cycles.
- `activate` is low for exactly 1 cycle between segments.

Write handshake:
- Once `wr_valid` is raised, `wr_addr` and `wr_color` hold until accepted.
- `wr_valid` never drops without acceptance.

Boundary conditions:
- Workers that do not raise busy hang the block in WAIT_BUSY. This is intentional; there is no timeout.
- A `worker_busy` glitch low before all bits have been seen high is ignored.
- `start` in the same cycle as `frame_done` is ignored.
- Reset mid-frame: asynchronous return to IDLE; `activate` drops immediately; any in-flight write is abandoned.

## Test plan
Bench setup: `N_WORKERS`=2, `JOBS_SUBDIVISION`=2, `WIDTH`=8, `HEIGHT`=2, with behavioural worker models.

- Full frame, `wr_ready`=1, worker busy for 5 cycles:
  - 16 writes, addresses 0..15 in order, then `frame_done` exactly once.
  - `pixel_start_x` = {-4,-3}, then {0,1}.
- Sphere.y=100:
  - row 0: `doty`=-100, `pixel_y_sqrd`=1;
  - row 1: `doty`=0, `pixel_y_sqrd`=0.
- Ordering: worker w, job j returns colour 0x100*w + j → `wr_color` sequence 0x000, 0x100, 0x001, 0x101 per segment.
- Backpressure: `wr_ready` toggling 1010… → `wr_addr`/`wr_color` stable while stalled; no duplicated or lost pixels.
- `start` pulsed while `busy`, and sphere changed mid-frame → ignored; outputs match the latched sphere.
- `rst` asserted during DRAIN → all outputs 0 in the same cycle; a new `start` produces a complete 16-pixel frame.
